// File: rtl/fb_branch_history_table.sv
// Firebird branch history table: direct-mapped direction and target predictor
// with registered lookup, trained by the branch-resolution stage.

`ifndef FB_32BITS
`define FB_32BITS [31:0]
`endif

module fb_branch_history_table #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic `FB_32BITS  lk_pc,
    output logic             pred_valid,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic `FB_32BITS  pred_pc,
    input  logic             upd_valid,
    input  logic `FB_32BITS  upd_pc,
    input  logic             upd_taken,
    input  logic `FB_32BITS  upd_target,
    input  logic             upd_mispredict,
    input  logic             flush,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int TAG_W = 32 - IDX_W;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_next;

    logic [IDX_W-1:0] up_idx;
    logic             up_hit;
    logic             we_ctr;
    logic             we_target;
    logic             we_alloc;
    logic [1:0]       ctr_new;

    // Lookup read path, evaluated on pre-edge table state
    always_comb begin
        lk_idx   = lk_pc[IDX_W-1:0];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_pc[31:IDX_W]);
        lk_taken = lk_hit && ctr_q[lk_idx][1];
        lk_next  = lk_taken ? target_q[lk_idx] : lk_pc + 32'd1;
    end

    // Update decode: counter training, target refresh or allocation
    always_comb begin
        up_idx    = upd_pc[IDX_W-1:0];
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == upd_pc[31:IDX_W]);
        we_ctr    = 1'b0;
        we_target = 1'b0;
        we_alloc  = 1'b0;
        ctr_new   = ctr_q[up_idx];
        if (upd_valid && !flush) begin
            if (up_hit) begin
                we_ctr = 1'b1;
                if (upd_taken) begin
                    we_target = 1'b1;
                    if (ctr_q[up_idx] != CTR_ST) begin
                        ctr_new = ctr_q[up_idx] + 2'd1;
                    end
                end else if (ctr_q[up_idx] != CTR_SNT) begin
                    ctr_new = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                we_alloc = 1'b1;
            end
        end
    end

    // Valid bits: cleared by flush, set on allocation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (we_alloc) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Tag, target and counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (we_alloc) begin
            tag_q[up_idx]    <= upd_pc[31:IDX_W];
            target_q[up_idx] <= upd_target;
            ctr_q[up_idx]    <= CTR_WT;
        end else begin
            if (we_ctr) begin
                ctr_q[up_idx] <= ctr_new;
            end
            if (we_target) begin
                target_q[up_idx] <= upd_target;
            end
        end
    end

    // Registered prediction; fields other than valid hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_hit   <= 1'b0;
            pred_taken <= 1'b0;
            pred_pc    <= '0;
        end else if (lk_valid) begin
            pred_valid <= 1'b1;
            pred_hit   <= lk_hit;
            pred_taken <= lk_taken;
            pred_pc    <= lk_next;
        end else begin
            pred_valid <= 1'b0;
        end
    end

    // Saturating misprediction count, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (upd_valid && upd_mispredict && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fb_branch_history_table.sv
// Directed testbench for fb_branch_history_table: vector table for the
// single-cycle behaviour plus sequences for saturation and async reset.

module tb_fb_branch_history_table;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush;
    logic [15:0] mispred_cnt;

    logic        u2_valid;
    logic        u2_mispredict;
    logic        p2_valid;
    logic        p2_hit;
    logic        p2_taken;
    logic [31:0] p2_pc;
    logic [3:0]  cnt2;

    int checks;
    int failures;

    fb_branch_history_table dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .flush(flush),
        .mispred_cnt(mispred_cnt)
    );

    fb_branch_history_table #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(1'b0), .lk_pc(32'd0),
        .pred_valid(p2_valid), .pred_hit(p2_hit),
        .pred_taken(p2_taken), .pred_pc(p2_pc),
        .upd_valid(u2_valid), .upd_pc(32'd3),
        .upd_taken(1'b1), .upd_target(32'h30),
        .upd_mispredict(u2_mispredict), .flush(1'b0),
        .mispred_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        fl;
        logic        pv;
        logic        ph;
        logic        pt;
        logic [31:0] ppc;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        lk_valid       = 1'b0;
        lk_pc          = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        flush          = 1'b0;
        u2_valid       = 1'b0;
        u2_mispredict  = 1'b0;

        //          lv  lpc     uv  upc     ut  utg     um  fl  pv  ph  pt  ppc     cnt
        vecs[0]  = '{1, 32'h40, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h41, 16'd0};
        vecs[1]  = '{0, 32'h00, 1, 32'h25, 1, 32'h10, 0, 0, 0, 0, 0, 32'h41, 16'd0};
        vecs[2]  = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 1, 32'h10, 16'd0};
        vecs[3]  = '{1, 32'h35, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h36, 16'd0};
        vecs[4]  = '{0, 32'h00, 1, 32'h25, 0, 32'h00, 1, 0, 0, 0, 0, 32'h36, 16'd1};
        vecs[5]  = '{0, 32'h00, 1, 32'h25, 0, 32'h00, 0, 0, 0, 0, 0, 32'h36, 16'd1};
        vecs[6]  = '{0, 32'h00, 1, 32'h25, 0, 32'h00, 0, 0, 0, 0, 0, 32'h36, 16'd1};
        vecs[7]  = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 0, 32'h26, 16'd1};
        vecs[8]  = '{1, 32'h25, 1, 32'h25, 1, 32'h12, 0, 0, 1, 1, 0, 32'h26, 16'd1};
        vecs[9]  = '{0, 32'h00, 1, 32'h25, 1, 32'h12, 0, 0, 0, 1, 0, 32'h26, 16'd1};
        vecs[10] = '{0, 32'h00, 1, 32'h25, 1, 32'h12, 0, 0, 0, 1, 0, 32'h26, 16'd1};
        vecs[11] = '{0, 32'h00, 1, 32'h25, 1, 32'h12, 0, 0, 0, 1, 0, 32'h26, 16'd1};
        vecs[12] = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 1, 32'h12, 16'd1};
        vecs[13] = '{0, 32'h00, 1, 32'h25, 0, 32'h00, 0, 0, 0, 1, 1, 32'h12, 16'd1};
        vecs[14] = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 1, 32'h12, 16'd1};
        vecs[15] = '{0, 32'h00, 0, 32'h25, 1, 32'h99, 1, 0, 0, 1, 1, 32'h12, 16'd1};
        vecs[16] = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 1, 32'h12, 16'd1};
        vecs[17] = '{1, 32'h07, 1, 32'h07, 1, 32'h70, 0, 0, 1, 0, 0, 32'h08, 16'd1};
        vecs[18] = '{1, 32'h07, 0, 32'h00, 0, 32'h00, 0, 0, 1, 1, 1, 32'h70, 16'd1};
        vecs[19] = '{0, 32'h00, 1, 32'h0B, 0, 32'hB0, 0, 0, 0, 1, 1, 32'h70, 16'd1};
        vecs[20] = '{1, 32'h0B, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h0C, 16'd1};
        vecs[21] = '{1, 32'h07, 1, 32'h09, 1, 32'h90, 1, 1, 1, 1, 1, 32'h70, 16'd2};
        vecs[22] = '{1, 32'h09, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h0A, 16'd2};
        vecs[23] = '{1, 32'h25, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h26, 16'd2};
        vecs[24] = '{1, 32'h07, 0, 32'h00, 0, 32'h00, 0, 0, 1, 0, 0, 32'h08, 16'd2};

        #2;
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_hit",   {31'd0, pred_hit},   32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_pc",    pred_pc,             32'd0);
        chk("rst_cnt",        {16'd0, mispred_cnt}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            lk_valid       = vecs[i].lv;
            lk_pc          = vecs[i].lpc;
            upd_valid      = vecs[i].uv;
            upd_pc         = vecs[i].upc;
            upd_taken      = vecs[i].ut;
            upd_target     = vecs[i].utg;
            upd_mispredict = vecs[i].um;
            flush          = vecs[i].fl;
            step();
            chk($sformatf("v%0d_pred_valid", i), {31'd0, pred_valid},
                {31'd0, vecs[i].pv});
            chk($sformatf("v%0d_pred_hit", i), {31'd0, pred_hit},
                {31'd0, vecs[i].ph});
            chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken},
                {31'd0, vecs[i].pt});
            chk($sformatf("v%0d_pred_pc", i), pred_pc, vecs[i].ppc);
            chk($sformatf("v%0d_cnt", i), {16'd0, mispred_cnt},
                {16'd0, vecs[i].cnt});
        end

        lk_valid       = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        flush          = 1'b0;

        u2_valid      = 1'b1;
        u2_mispredict = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 9) chk("cnt4_after10", {28'd0, cnt2}, 32'd10);
        end
        u2_valid      = 1'b0;
        u2_mispredict = 1'b0;
        chk("cnt4_saturated", {28'd0, cnt2}, 32'd15);

        lk_valid = 1'b1;
        lk_pc    = 32'h50;
        step();
        chk("pre_rst_pred_valid", {31'd0, pred_valid}, 32'd1);
        chk("pre_rst_pred_pc", pred_pc, 32'h51);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("async_pred_pc", pred_pc, 32'd0);
        chk("async_cnt", {16'd0, mispred_cnt}, 32'd0);
        chk("async_cnt4", {28'd0, cnt2}, 32'd0);

        @(negedge clk);
        rst_n    = 1'b1;
        lk_valid = 1'b1;
        lk_pc    = 32'h25;
        step();
        chk("post_rst_hit", {31'd0, pred_hit}, 32'd0);
        chk("post_rst_pc", pred_pc, 32'h26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
